iram_arbiter: RTL and testbench

IRAM_ARBITER -- requirements
Module: iram_arbiter

---
 rtl/iram_arbiter.sv | 121 ++++++++++++
 tb/tb_iram_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iram_arbiter.sv
// Round-robin arbiter granting one instruction-fetch port and one load/store
// port access to a single-cycle iram, one transaction in flight at a time.
module iram_arbiter #(
    parameter logic [63:0] RAM_START = 64'h1000,
    parameter int unsigned RAM_SIZE  = 256
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [63:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic [63:0] mem_rdata,
    output logic        HWRITE,
    output logic [63:0] HADDR,
    output logic [63:0] HWDATA,
    input  logic [63:0] HRDATA,
    output logic        busy
);

    localparam logic [63:0] RAM_END = RAM_START + 64'(RAM_SIZE) - 64'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        last_mem_q;
    logic        win_mem_q;
    logic        inrange_q;
    logic        wr_q;

    logic        grant_mem_c;
    logic [63:0] sel_addr_c;
    logic [63:0] sel_wdata_c;
    logic        sel_wr_c;
    logic        sel_inrange_c;

    // Load/store wins when alone, or when both request and fetch did not lose last time.
    always_comb begin
        grant_mem_c   = mem_req && (!if_req || !last_mem_q);
        sel_addr_c    = grant_mem_c ? mem_addr : if_addr;
        sel_wdata_c   = grant_mem_c ? mem_wdata : 64'd0;
        sel_wr_c      = grant_mem_c && mem_write;
        sel_inrange_c = (sel_addr_c >= RAM_START) && (sel_addr_c < RAM_END);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET) begin
            state_q    <= IDLE;
            last_mem_q <= 1'b1;
            win_mem_q  <= 1'b0;
            inrange_q  <= 1'b0;
            wr_q       <= 1'b0;
            busy       <= 1'b0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= 64'd0;
            mem_done   <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= 64'd0;
            HWRITE     <= 1'b0;
            HADDR      <= 64'd0;
            HWDATA     <= 64'd0;
        end else begin
            if_done  <= 1'b0;
            if_err   <= 1'b0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
            HWRITE   <= 1'b0;
            HADDR    <= 64'd0;
            HWDATA   <= 64'd0;
            case (state_q)
                IDLE: begin
                    if (if_req || mem_req) begin
                        state_q    <= ACCESS;
                        busy       <= 1'b1;
                        win_mem_q  <= grant_mem_c;
                        last_mem_q <= grant_mem_c;
                        inrange_q  <= sel_inrange_c;
                        wr_q       <= sel_wr_c;
                        // Out-of-range requests never reach the iram bus.
                        if (sel_inrange_c) begin
                            HWRITE <= sel_wr_c;
                            HADDR  <= sel_addr_c;
                            HWDATA <= sel_wdata_c;
                        end
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    if (inrange_q && !wr_q) begin
                        if (win_mem_q) mem_rdata <= HRDATA;
                        else           if_rdata  <= HRDATA;
                    end
                    if (win_mem_q) begin
                        mem_done <= 1'b1;
                        mem_err  <= !inrange_q;
                    end else begin
                        if_done <= 1'b1;
                        if_err  <= !inrange_q;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iram_arbiter.sv
// Directed bench for iram_arbiter with a 32-word iram model behind the bus.
module tb_iram_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done, if_err;
    logic [63:0] if_rdata;
    logic        mem_req, mem_write;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_done, mem_err;
    logic [63:0] mem_rdata;
    logic        HWRITE;
    logic [63:0] HADDR, HWDATA, HRDATA;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] iram [32];
    logic [63:0] off_w;
    logic [63:0] cmp_v;

    always #5 HCLK = ~HCLK;

    iram_arbiter #(.RAM_START(64'h1000), .RAM_SIZE(256)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .busy(busy)
    );

    // Single-cycle iram: combinational read, write on the clock edge.
    assign off_w  = HADDR - 64'h1000;
    assign HRDATA = iram[off_w[7:3]];
    always @(posedge HCLK) if (HWRITE) iram[off_w[7:3]] <= HWDATA;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) iram[i] = 64'd0;
        iram[3]  = 64'hCAFE_F00D_DEAD_BEEF;
        iram[31] = 64'h5A5A_5A5A_5A5A_5A5A;
        HRESET = 1'b0; if_req = 1'b0; if_addr = 64'd0;
        mem_req = 1'b0; mem_write = 1'b0; mem_addr = 64'd0; mem_wdata = 64'd0;
        #1;
        // reset, with a request held high that must be ignored
        mem_req = 1'b1; mem_addr = 64'h1010;
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hwrite", 64'(HWRITE), 64'd0);
        check("rst_haddr", HADDR, 64'd0);
        check("rst_if_rdata", if_rdata, 64'd0);
        check("rst_mem_rdata", mem_rdata, 64'd0);
        check("rst_done", 64'({if_done, mem_done}), 64'd0);
        mem_req = 1'b0;
        HRESET = 1'b1;
        tick();

        // store 0x1010
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 64'h1010; mem_wdata = 64'h1122334455667788;
        tick();
        check("st_busy", 64'(busy), 64'd1);
        check("st_hwrite", 64'(HWRITE), 64'd1);
        check("st_haddr", HADDR, 64'h1010);
        check("st_hwdata", HWDATA, 64'h1122334455667788);
        check("st_done_early", 64'(mem_done), 64'd0);
        mem_req = 1'b0; mem_write = 1'b0;
        tick();
        check("st_hwrite_off", 64'(HWRITE), 64'd0);
        check("st_done", 64'(mem_done), 64'd1);
        check("st_err", 64'(mem_err), 64'd0);
        check("st_if_done", 64'(if_done), 64'd0);
        tick();
        check("st_done_pulse", 64'(mem_done), 64'd0);
        check("st_idle_busy", 64'(busy), 64'd0);

        // fetch back 0x1010
        if_req = 1'b1; if_addr = 64'h1010;
        tick();
        check("fe_hwrite", 64'(HWRITE), 64'd0);
        check("fe_haddr", HADDR, 64'h1010);
        if_req = 1'b0;
        tick();
        check("fe_done", 64'(if_done), 64'd1);
        check("fe_err", 64'(if_err), 64'd0);
        check("fe_rdata", if_rdata, 64'h1122334455667788);
        check("fe_mem_done", 64'(mem_done), 64'd0);
        tick();

        // load 0x1018, req dropped and inputs changed after grant
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'h1018;
        tick();
        mem_req = 1'b0; mem_write = 1'b1; mem_addr = 64'h1030; mem_wdata = 64'hFFFF;
        check("ld_haddr", HADDR, 64'h1018);
        check("ld_hwrite", 64'(HWRITE), 64'd0);
        tick();
        check("ld_done", 64'(mem_done), 64'd1);
        check("ld_rdata", mem_rdata, 64'hCAFE_F00D_DEAD_BEEF);
        tick();
        check("ld_no_new", 64'(busy), 64'd0);

        // store at RAM_START+RAM_SIZE-8 is out of range
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 64'h10F8; mem_wdata = 64'h0123;
        tick();
        check("oor_hwrite", 64'(HWRITE), 64'd0);
        check("oor_haddr", HADDR, 64'd0);
        check("oor_hwdata", HWDATA, 64'd0);
        mem_req = 1'b0; mem_write = 1'b0;
        tick();
        check("oor_done", 64'(mem_done), 64'd1);
        check("oor_err", 64'(mem_err), 64'd1);
        check("oor_rdata", mem_rdata, 64'hCAFE_F00D_DEAD_BEEF);
        tick();
        cmp_v = iram[31];
        check("oor_iram", cmp_v, 64'h5A5A_5A5A_5A5A_5A5A);

        // fetch below RAM_START
        if_req = 1'b1; if_addr = 64'h0FFF;
        tick();
        if_req = 1'b0;
        check("lo_haddr", HADDR, 64'd0);
        tick();
        check("lo_done", 64'(if_done), 64'd1);
        check("lo_err", 64'(if_err), 64'd1);
        check("lo_rdata", if_rdata, 64'h1122334455667788);
        tick();

        // both requesting right after reset: IF, MEM, IF, MEM
        HRESET = 1'b0;
        tick();
        HRESET = 1'b1;
        if_req = 1'b1; if_addr = 64'h1010;
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = 64'h1018;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_haddr%0d", k), HADDR, (k % 2 == 0) ? 64'h1010 : 64'h1018);
            tick();
            check($sformatf("rr_if_done%0d", k), 64'(if_done), (k % 2 == 0) ? 64'd1 : 64'd0);
            check($sformatf("rr_mem_done%0d", k), 64'(mem_done), (k % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            check($sformatf("rr_idle%0d", k), 64'({if_done, mem_done}), 64'd0);
        end
        if_req = 1'b0; mem_req = 1'b0;
        check("rr_if_rdata", if_rdata, 64'h1122334455667788);
        check("rr_mem_rdata", mem_rdata, 64'hCAFE_F00D_DEAD_BEEF);
        tick(); tick(); tick();

        // reset during ACCESS of a store
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 64'h1020; mem_wdata = 64'h77;
        tick();
        check("ab_hwrite", 64'(HWRITE), 64'd1);
        HRESET = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
        tick();
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_hwrite_off", 64'(HWRITE), 64'd0);
        check("ab_done", 64'(mem_done), 64'd0);
        HRESET = 1'b1;
        tick();
        check("ab_done_after", 64'(mem_done), 64'd0);
        check("ab_busy_after", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
